// File: rtl/seg7_score_display.sv
// Purpose: binary-to-BCD (shift-add-3, one bit per clock) driver for DIGITS active-low 7-seg digits.
// Latency: load at edge N -> hex/done valid after edge N+BIN_W+1; busy high while converting.
// Backpressure: none; load while busy is dropped. Optional blink masking under `SEG7_BLINK_EN.
module seg7_score_display #(
    parameter int DIGITS    = 2,
    parameter int BIN_W     = 7,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic                  blink,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int HEX_W = 7 * DIGITS;
    localparam int unsigned MAX_VAL = 10**DIGITS - 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_pend;
    logic               ovf_q;
    logic               done_q;
    logic [HEX_W-1:0]   hex_q;
    logic [HEX_W-1:0]   hex_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; SHIFT runs exactly BIN_W cycles.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:   if (load) state_d = ST_SHIFT;
            ST_SHIFT:  if (bit_cnt == CNT_W'(BIN_W - 1)) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Double-dabble step: correct each BCD nibble >=5 by +3, then shift {bcd, bin} left.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sr_q[BIN_W + 4*k +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*k +: 4] = sr_q[BIN_W + 4*k +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    // Digit patterns to commit: dashes on overflow, else leading zeros blanked above digit 0.
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        lead    = 1'b1;
        nib     = 4'd0;
        hex_nxt = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = sr_q[BIN_W + 4*k +: 4];
            if (ovf_pend) begin
                hex_nxt[7*k +: 7] = SEG_DASH;
            end else if (lead && (nib == 4'd0) && (k != 0)) begin
                hex_nxt[7*k +: 7] = SEG_BLANK;
            end else begin
                hex_nxt[7*k +: 7] = seg_decode(nib);
                lead              = 1'b0;
            end
        end
    end

    // Conversion datapath and committed output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            hex_q    <= '1;
        end else begin
            done_q <= (state_q == ST_UPDATE);
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        sr_q     <= {{BCD_W{1'b0}}, value};
                        ovf_pend <= (32'(value) > MAX_VAL);
                        bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    sr_q    <= sr_shift;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                ST_UPDATE: begin
                    hex_q <= hex_nxt;
                    ovf_q <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign done     = done_q;
    assign overflow = ovf_q;

`ifdef SEG7_BLINK_EN
    localparam int BL_W = $clog2(BLINK_DIV + 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;

    // Free-running blink timer, held cleared while blink is not requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

    assign hex = (blink && blink_phase) ? {HEX_W{1'b1}} : hex_q;
`else
    localparam int BLINK_DIV_UNUSED = BLINK_DIV;
    logic blink_unused;
    assign blink_unused = blink;
    assign hex          = hex_q;
`endif

endmodule
